// File: rtl/epy_mem_pkg.sv
// Shared constants for the Sistema_Epy memory copy/fill master.
// State codes are plain localparams so older tools can read them.
package epy_mem_pkg;

  localparam int ADDR_W = 13;
  localparam int DEPTH  = 5120;
  localparam int LEN_W  = 14;

  localparam logic [3:0] BE_ALL = 4'hF;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_CHECK   = 3'd1;
  localparam state_t ST_RD_REQ  = 3'd2;
  localparam state_t ST_RD_WAIT = 3'd3;
  localparam state_t ST_WR_REQ  = 3'd4;
  localparam state_t ST_FIN     = 3'd5;

endpackage

// File: rtl/epy_mem_copy_master.sv
// Avalon-MM master that copies a block of words or fills a range with a constant,
// sharing the on-chip RAM with the CPU and obeying waitrequest.
module epy_mem_copy_master #(
  parameter int ADDR_W       = epy_mem_pkg::ADDR_W,
  parameter int DEPTH        = epy_mem_pkg::DEPTH,
  parameter int LEN_W        = epy_mem_pkg::LEN_W,
  parameter int READ_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              fill_en,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [LEN_W-1:0]  len,
  input  logic [31:0]       fill_data,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] avm_address,
  output logic [3:0]        avm_byteenable,
  output logic              avm_chipselect,
  output logic              avm_read,
  output logic              avm_write,
  output logic [31:0]       avm_writedata,
  input  logic [31:0]       avm_readdata,
  input  logic              avm_waitrequest
);
  import epy_mem_pkg::*;

  localparam logic [LEN_W:0] DEPTH_EXT = (LEN_W+1)'(DEPTH);

  state_t            state;
  logic [ADDR_W-1:0] src_ptr;
  logic [ADDR_W-1:0] dst_ptr;
  logic [LEN_W-1:0]  remaining;
  logic              fill_mode;
  logic              err_flag;
  logic [31:0]       fill_reg;
  logic [31:0]       data_reg;
  logic [1:0]        lat_cnt;

  logic [LEN_W:0] dst_end;
  logic [LEN_W:0] src_end;
  logic           range_bad;
  logic           rd_phase;
  logic           wr_phase;

  // End addresses are one bit wider than len so an oversized command cannot wrap past the check.
  assign dst_end   = (LEN_W+1)'(dst_ptr) + (LEN_W+1)'(remaining);
  assign src_end   = (LEN_W+1)'(src_ptr) + (LEN_W+1)'(remaining);
  assign range_bad = (dst_end > DEPTH_EXT) || (!fill_mode && (src_end > DEPTH_EXT));

  assign rd_phase = (state == ST_RD_REQ);
  assign wr_phase = (state == ST_WR_REQ);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      src_ptr   <= '0;
      dst_ptr   <= '0;
      remaining <= '0;
      fill_mode <= 1'b0;
      err_flag  <= 1'b0;
      fill_reg  <= '0;
      data_reg  <= '0;
      lat_cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            src_ptr   <= src_addr;
            dst_ptr   <= dst_addr;
            remaining <= len;
            fill_mode <= fill_en;
            fill_reg  <= fill_data;
            err_flag  <= 1'b0;
            state     <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (remaining == '0) begin
            state <= ST_FIN;
          end else if (range_bad) begin
            err_flag <= 1'b1;
            state    <= ST_FIN;
          end else begin
            state <= fill_mode ? ST_WR_REQ : ST_RD_REQ;
          end
        end
        ST_RD_REQ: begin
          if (!avm_waitrequest) begin
            lat_cnt <= 2'(READ_LATENCY);
            state   <= ST_RD_WAIT;
          end
        end
        // The RAM has no readdatavalid, so data is taken on the cycle the count expires.
        ST_RD_WAIT: begin
          lat_cnt <= lat_cnt - 2'd1;
          if (lat_cnt == 2'd1) begin
            data_reg <= avm_readdata;
            state    <= ST_WR_REQ;
          end
        end
        ST_WR_REQ: begin
          if (!avm_waitrequest) begin
            src_ptr   <= src_ptr + ADDR_W'(1);
            dst_ptr   <= dst_ptr + ADDR_W'(1);
            remaining <= remaining - LEN_W'(1);
            if (remaining == LEN_W'(1)) begin
              state <= ST_FIN;
            end else if (!fill_mode) begin
              state <= ST_RD_REQ;
            end
          end
        end
        ST_FIN: begin
          err_flag <= 1'b0;
          state    <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    busy           = (state != ST_IDLE);
    done           = (state == ST_FIN);
    err            = (state == ST_FIN) && err_flag;
    avm_read       = rd_phase;
    avm_write      = wr_phase;
    avm_chipselect = rd_phase | wr_phase;
    avm_byteenable = (rd_phase | wr_phase) ? BE_ALL : 4'h0;
    avm_address    = '0;
    avm_writedata  = '0;
    if (rd_phase) begin
      avm_address = src_ptr;
    end
    if (wr_phase) begin
      avm_address   = dst_ptr;
      avm_writedata = fill_mode ? fill_reg : data_reg;
    end
  end

endmodule
